coef_bank_loader: RTL and testbench

- Writer-side companion to the coefficient ROM sequencer used by the FIR.
- Accepts a stream of 24-bit FIR coefficients over a valid/ready handshake into the shadow half of a two-bank coefficient RAM.
- Verifies a trailing checksum word, then swaps banks on a frame boundary.
- The FIR-side sequencer reads the active bank through a registered read port, so coefficients are replaced without glitching a filter pass.

---
 rtl/coef_bank_loader.sv | 111 +++++++++++
 tb/tb_coef_bank_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/coef_bank_loader.sv
// Two-bank coefficient RAM loader: streams NTAPS words into the shadow bank,
// verifies a trailing checksum, and swaps banks on the sequencer's frame boundary.
module coef_bank_loader #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NTAPS  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              active_bank,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NTAPS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, PEND} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] acc, acc_n;
    logic              bank_n, done_n, err_n, wr_en, xfer;

    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    assign wr_ready = (state == LOAD) || (state == CHECK);
    assign busy     = (state != IDLE);
    assign xfer     = wr_valid && wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            active_bank <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            rd_data     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            acc         <= acc_n;
            active_bank <= bank_n;
            load_done   <= done_n;
            load_err    <= err_n;
            rd_data     <= mem[{active_bank, rd_addr}];
        end
    end

    // Shadow-bank writes never alias the active bank, so reads need no bypass.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{~active_bank, cnt}] <= wr_data;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        bank_n  = active_bank;
        done_n  = 1'b0;
        err_n   = 1'b0;
        wr_en   = 1'b0;
        // load_start overrides everything: start, abort, and beats any transfer or commit.
        if (load_start) begin
            cnt_n   = '0;
            acc_n   = '0;
            state_n = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        wr_en = 1'b1;
                        acc_n = acc + wr_data;
                        cnt_n = cnt + 1'b1;
                        if (cnt == LAST)
                            state_n = CHECK;
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (wr_data == acc) begin
                            state_n = PEND;
                        end else begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                PEND: begin
                    if (frame_start) begin
                        bank_n  = ~active_bank;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

endmodule

// File: tb/tb_coef_bank_loader.sv
// Directed bench for coef_bank_loader with a queued read-port scoreboard
// and a bench-side model of both RAM banks.
module tb_coef_bank_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic [23:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        frame_start = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [23:0] rd_data;
    logic        active_bank;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int tests = 0;
    int fails = 0;

    logic [23:0] model_mem [2][256];
    logic        model_bank = 1'b0;
    logic [23:0] sb_q [$];

    coef_bank_loader #(.DATA_W(24), .ADDR_W(8), .NTAPS(256)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .frame_start(frame_start),
        .rd_addr(rd_addr), .rd_data(rd_data), .active_bank(active_bank),
        .busy(busy), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] wval(input int kind, input int k);
        case (kind)
            0:       return 24'(k);
            1:       return 24'hFFFFFF;
            2:       return 24'(3 * k);
            3:       return 24'(k + 'h100);
            default: return ~24'(k);
        endcase
    endfunction

    // Offer one word until accepted; bp randomises wr_valid.
    task automatic push_word(input logic [23:0] d, input bit bp, output bit ok);
        bit acc;
        ok = 1'b0;
        for (int g = 0; g < 200 && !ok; g++) begin
            wr_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = wr_valid ? d : 24'($urandom);
            acc      = wr_valid && wr_ready;
            tick();
            ok = acc;
        end
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_chk(input logic [7:0] addr);
        rd_addr = addr;
        sb_q.push_back(model_mem[model_bank][addr]);
        tick();
        check("rd_data", {8'h0, rd_data}, {8'h0, sb_q.pop_front()});
    endtask

    task automatic do_load(input int kind, input bit bp, input bit use_csum,
                           input logic [23:0] csum_in, input bit fs_before_csum,
                           output int accepted);
        logic [23:0] sum;
        logic [23:0] w;
        bit ok;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        sum = '0;
        accepted = 0;
        for (int k = 0; k < 256; k++) begin
            w = wval(kind, k);
            push_word(w, bp, ok);
            if (ok) begin
                accepted++;
                model_mem[!model_bank][k] = w;
                sum = sum + w;
            end
        end
        if (fs_before_csum) begin
            wr_valid = 1'b0;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            check("no_swap_in_check", {31'd0, active_bank}, {31'd0, model_bank});
            check("still_check_ready", {31'd0, wr_ready}, 32'd1);
        end
        push_word(use_csum ? csum_in : sum, bp, ok);
        if (ok) accepted++;
        wr_valid = 1'b0;
    endtask

    task automatic commit(input int wait_cycles);
        check("pend_busy", {31'd0, busy}, 32'd1);
        check("pend_ready", {31'd0, wr_ready}, 32'd0);
        check("pend_no_err", {31'd0, load_err}, 32'd0);
        repeat (wait_cycles) tick();
        check("pre_swap_bank", {31'd0, active_bank}, {31'd0, model_bank});
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_bank = !model_bank;
        check("swap_bank", {31'd0, active_bank}, {31'd0, model_bank});
        check("load_done_pulse", {31'd0, load_done}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        tick();
        check("load_done_clear", {31'd0, load_done}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"}, {8'h0, rd_data}, 32'd0);
        check({tag, "_bank"}, {31'd0, active_bank}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ready"}, {31'd0, wr_ready}, 32'd0);
        check({tag, "_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_err"}, {31'd0, load_err}, 32'd0);
    endtask

    initial begin
        int n;
        bit ok;

        #1 reset = 1'b1;
        #2 check_all_zero("reset");
        tick();
        reset = 1'b0;
        tick();

        // 1. Good load with ramp, literal checksum
        check("idle_ready", {31'd0, wr_ready}, 32'd0);
        do_load(0, 1'b0, 1'b1, 24'h007F80, 1'b0, n);
        commit(10);
        read_chk(8'd5);
        read_chk(8'd0);
        read_chk(8'd255);

        // 2. Checksum wrap
        do_load(1, 1'b0, 1'b1, 24'hFFFF00, 1'b0, n);
        commit(3);
        read_chk(8'd200);

        // 3. Bad checksum
        do_load(0, 1'b0, 1'b1, 24'h000000, 1'b0, n);
        check("bad_err_pulse", {31'd0, load_err}, 32'd1);
        check("bad_idle", {31'd0, busy}, 32'd0);
        check("bad_bank", {31'd0, active_bank}, {31'd0, model_bank});
        tick();
        check("bad_err_clear", {31'd0, load_err}, 32'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("idle_frame_no_swap", {31'd0, active_bank}, {31'd0, model_bank});
        check("idle_frame_no_done", {31'd0, load_done}, 32'd0);
        read_chk(8'd7);
        read_chk(8'd130);

        // 4. Backpressure
        check("idle_ready2", {31'd0, wr_ready}, 32'd0);
        do_load(2, 1'b1, 1'b0, 24'h0, 1'b0, n);
        check("bp_accepted", 32'(n), 32'd257);
        commit(2);
        read_chk(8'd1);
        read_chk(8'd100);
        read_chk(8'd255);

        // 5. Abort at word 100, load_start coincides with an offered word
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            push_word(wval(4, k), 1'b0, ok);
            if (ok) model_mem[!model_bank][k] = wval(4, k);
        end
        load_start = 1'b1;
        wr_valid = 1'b1;
        wr_data = 24'hABCDEF;
        tick();
        load_start = 1'b0;
        wr_valid = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd1);
        check("abort_no_done", {31'd0, load_done}, 32'd0);
        do_load(3, 1'b0, 1'b0, 24'h0, 1'b1, n);
        commit(1);
        read_chk(8'd0);
        read_chk(8'd99);
        read_chk(8'd100);
        read_chk(8'd255);

        // 6. Async reset mid-load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            push_word(wval(2, k), 1'b0, ok);
            if (ok) model_mem[!model_bank][k] = wval(2, k);
        end
        wr_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        model_bank = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        read_chk(8'd10);
        do_load(0, 1'b0, 1'b0, 24'h0, 1'b0, n);
        commit(4);
        read_chk(8'd42);
        read_chk(8'd250);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
